// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI receive parser: FSM states,
// status nibbles, System Common markers and the per-status data length.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_e;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHPRESS  = 4'hD;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  // Program Change and Channel Pressure carry one data byte; every other
  // channel-voice message carries two.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    if (status[7:4] == ST_PROG || status[7:4] == ST_CHPRESS)
      return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational decode of one received MIDI byte into its class:
// real-time, channel-voice status, system-common status or data.
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_rt_o,
  output logic       is_cv_o,
  output logic       is_sc_o,
  output logic       is_data_o
);

  assign is_rt_o   = (byte_i >= RT_MIN);
  assign is_sc_o   = (byte_i[7:3] == 5'b11110);
  assign is_cv_o   = byte_i[7] && (byte_i[7:4] != 4'hF);
  assign is_data_o = ~byte_i[7];

endmodule

// File: rtl/midi_rx_parser.sv
// Pops bytes from the UART RX FIFO and assembles MIDI channel-voice messages,
// passing real-time bytes straight through and discarding SysEx payloads.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter bit         OMNI           = 1'b1,
  parameter logic [3:0] CHANNEL        = 4'd0,
  parameter bit         NOTEON0_AS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       sync_err
);

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] data1_q, data1_d;
  logic       msgValid_q, msgValid_d;
  logic [7:0] msgStatus_q, msgStatus_d;
  logic [6:0] msgData1_q, msgData1_d;
  logic [6:0] msgData2_q, msgData2_d;
  logic       rtValid_q, rtValid_d;
  logic [7:0] rtByte_q, rtByte_d;
  logic       syncErr_q, syncErr_d;

  logic       pop;
  logic       isRt, isCv, isSc, isData;
  logic       emit, chanOk;
  logic [7:0] emitStatus;
  logic [6:0] emitD1, emitD2;

  midi_byte_classify u_classify (
    .byte_i    (r_data),
    .is_rt_o   (isRt),
    .is_cv_o   (isCv),
    .is_sc_o   (isSc),
    .is_data_o (isData)
  );

  assign rd_uart = ~rx_empty & ~reset;
  assign pop     = rd_uart;
  assign chanOk  = OMNI || (status_q[3:0] == CHANNEL);

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    data1_d     = data1_q;
    msgValid_d  = 1'b0;
    msgStatus_d = msgStatus_q;
    msgData1_d  = msgData1_q;
    msgData2_d  = msgData2_q;
    rtValid_d   = 1'b0;
    rtByte_d    = rtByte_q;
    syncErr_d   = 1'b0;
    emit        = 1'b0;
    emitD1      = data1_q;
    emitD2      = 7'd0;
    emitStatus  = status_q;

    // Real-time bytes bypass the FSM so a partial message survives them.
    if (pop) begin
      if (isRt) begin
        rtValid_d = 1'b1;
        rtByte_d  = r_data;
      end else if (isCv) begin
        status_d = r_data;
        state_d  = WAIT_D1;
      end else if (isSc) begin
        status_d = 8'd0;
        state_d  = (r_data == SYSEX_START) ? SYSEX : IDLE;
      end else if (isData) begin
        case (state_q)
          IDLE:    syncErr_d = 1'b1;
          WAIT_D1: begin
            data1_d = r_data[6:0];
            if (data_len(status_q) == 2'd1) begin
              emit   = 1'b1;
              emitD1 = r_data[6:0];
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emitD2  = r_data[6:0];
            state_d = WAIT_D1;
          end
          SYSEX:   ;
          default: ;
        endcase
      end
    end

    if (NOTEON0_AS_OFF && status_q[7:4] == ST_NOTE_ON && emitD2 == 7'd0) begin
      emitStatus = {ST_NOTE_OFF, status_q[3:0]};
      emitD2     = 7'h40;
    end

    // Filtered-out channels still advance the FSM, they just never pulse.
    if (emit && chanOk) begin
      msgValid_d  = 1'b1;
      msgStatus_d = emitStatus;
      msgData1_d  = emitD1;
      msgData2_d  = emitD2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      status_q    <= 8'd0;
      data1_q     <= 7'd0;
      msgValid_q  <= 1'b0;
      msgStatus_q <= 8'd0;
      msgData1_q  <= 7'd0;
      msgData2_q  <= 7'd0;
      rtValid_q   <= 1'b0;
      rtByte_q    <= 8'd0;
      syncErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      data1_q     <= data1_d;
      msgValid_q  <= msgValid_d;
      msgStatus_q <= msgStatus_d;
      msgData1_q  <= msgData1_d;
      msgData2_q  <= msgData2_d;
      rtValid_q   <= rtValid_d;
      rtByte_q    <= rtByte_d;
      syncErr_q   <= syncErr_d;
    end
  end

  assign msg_valid  = msgValid_q;
  assign msg_status = msgStatus_q;
  assign msg_data1  = msgData1_q;
  assign msg_data2  = msgData2_q;
  assign rt_valid   = rtValid_q;
  assign rt_byte    = rtByte_q;
  assign sync_err   = syncErr_q;

endmodule
